i2c_slave_responder: RTL
========================

Name: i2c_slave_responder

Overview:
- Target-side (responder) end of the two-wire SDA/SCL bus driven by the LC3 core's bus master.
- Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address, ACKs, and moves bytes in both directions.
- Delivers written bytes to local logic and fetches read bytes from it.
- Drives SDA open-drain only: pull low or release.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit bus address this block answers to.
- SYNC_STAGES, 2, flip-flop depth of the SCL/SDA input synchronisers (min 2).

Ports:
- clk  in  1  system clock; SCL period must be at least 8 clk cycles.
- rst_n  in  1  synchronous active-low reset.
- scl_in  in  1  raw SCL bus level.
- sda_in  in  1  raw SDA bus level; z resolved to 1 externally.
- sda_oe  out  1  1 = pull SDA low; 0 = release.
- rx_data  out  8  last byte written by the master.
- rx_valid  out  1  one-cycle pulse; rx_data is new.
- tx_data  in  8  byte to return on a master read.
- tx_req  out  1  one-cycle pulse; local logic must present the next tx_data.
- rw  out  1  R/W bit of the current transfer (1 = read).
- busy  out  1  high from address match until STOP or mismatch.
- stop_det  out  1  one-cycle pulse on every detected STOP.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - State goes to IDLE.
  - sda_oe, rx_valid, tx_req, busy, stop_det, rw are 0; rx_data is 8'h00.
  - Synchronisers are preset to 1.
  - Reset mid-transfer releases SDA on the next clk edge.
- Line conditioning:
  - scl_s/sda_s are taken after SYNC_STAGES flops.
  - Rise/fall flags are computed from scl_s/sda_s versus their 1-cycle-delayed copies.
- Bus conditions:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Both are checked before bit logic and override any state.
  - START from any state goes to ADDR with the bit counter cleared (repeated START allowed).
  - STOP from any state goes to IDLE, clears busy, releases SDA, and pulses stop_det.
- Bit timing:
  - Data is sampled on SCL rise.
  - sda_oe changes only on SCL fall; SDA must never change while SCL is high.
  - A 3-bit counter counts bits MSB first.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits on SCL rises. After the 8th rise, the top 7 bits are compared with SLAVE_ADDR and bit 0 is latched to rw.
    - Match: on the next SCL fall go to ADDR_ACK, set sda_oe=1 and busy=1.
    - Mismatch: go to WAIT_STOP with sda_oe=0.
  - ADDR_ACK: hold sda_oe=1 through one SCL high.
    - rw=0: on the next SCL fall, release SDA and go to WR_DATA.
    - rw=1: pulse tx_req at the ACK-bit SCL rise. On the next SCL fall, load the shift register from tx_data, drive bit 7 (sda_oe = ~bit), and go to RD_DATA.
  - WR_DATA: shift 8 bits. On the 8th rise, update rx_data and pulse rx_valid (1 clk after that rise). Next SCL fall goes to WR_ACK with sda_oe=1.
  - WR_ACK: one SCL pulse with SDA low, then go to WR_DATA on SCL fall with SDA released. Writes continue unbounded until STOP or START.
  - RD_DATA: shift out on each SCL fall; sda_oe = ~current bit. After the 8th bit's SCL fall, release SDA and go to RD_ACK.
  - RD_ACK: sample the master's bit on SCL rise.
    - 0 (ACK): pulse tx_req. Next SCL fall loads tx_data and goes to RD_DATA.
    - 1 (NACK): go to WAIT_STOP, clear busy.
  - WAIT_STOP: SDA released; ignore bits until START or STOP.
- tx_data contract: tx_data must be stable from 2 clk after tx_req until the following SCL fall.
- Simultaneous events:
  - STOP/START have priority over SCL-edge processing in the same cycle.
  - rx_valid and stop_det may pulse on different cycles only; they are never merged.

Optional Feature:
- Macro I2C_GENERAL_CALL_EN.
- Defined: address byte 8'h00 (general call, write) is also ACKed as a write transfer, and an extra output port gcall (1 bit, reset 0) is high for that transfer until STOP or START.
- Undefined: 8'h00 is a mismatch; the port does not exist.

Decomposition:
- Package i2c_pkg:
  - state encoding (IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP);
  - constants I2C_ACK=1'b0, I2C_NACK=1'b1, I2C_BYTE_BITS=8.
- Sub-module i2c_line_sync: SYNC_STAGES synchroniser plus rise/fall/START/STOP detection for both lines; it is reused by the master side.

Test Plan:
- Write to address 0x50, data 0xA5, 0x3C, then STOP → ACK driven on the address and both data bits; rx_valid pulses twice with rx_data 0xA5 then 0x3C; stop_det pulses once; busy ends at 0.
- Address 0x51 written → no ACK (SDA stays 1); no rx_valid or tx_req; WAIT_STOP until STOP.
- Read from address 0x50 with tx_data 0x96 then 0x0F; master ACKs byte 1 and NACKs byte 2 → bus carries 1001_0110 then 0000_1111; tx_req pulses twice; state is WAIT_STOP after the NACK.
- Write 0x50 with data 0x12, then repeated START, then read 0x50 → rx_data=0x12, rw switches to 1, the read proceeds without an intervening STOP.
- rst_n driven low during bit 4 of a read byte with SDA held low → sda_oe=0 on the next clk; state is IDLE; the next full transaction completes normally.
- Glitch: SDA toggles while SCL is high mid-byte (a STOP-shaped edge) → treated as STOP, stop_det pulses, no rx_valid.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: responder state encoding, bus constants and the
// address-compare helper used by the responder and master sides.
package i2c_pkg;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ADDR      = 3'd1;
    localparam logic [2:0] ADDR_ACK  = 3'd2;
    localparam logic [2:0] WR_DATA   = 3'd3;
    localparam logic [2:0] WR_ACK    = 3'd4;
    localparam logic [2:0] RD_DATA   = 3'd5;
    localparam logic [2:0] RD_ACK    = 3'd6;
    localparam logic [2:0] WAIT_STOP = 3'd7;

    localparam logic I2C_ACK       = 1'b0;
    localparam logic I2C_NACK      = 1'b1;
    localparam int   I2C_BYTE_BITS = 8;

    // Address byte is {addr[6:0], rw}; only the upper seven bits identify the target.
    function automatic logic addr_hit(input logic [7:0] addr_byte, input logic [6:0] own_addr);
        return addr_byte[7:1] == own_addr;
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA input synchroniser with edge flags and START/STOP detection;
// shared by the responder and the master side of the bus.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_ff;
    logic [SYNC_STAGES-1:0] sda_ff;
    logic                   scl_s;
    logic                   scl_d;
    logic                   sda_d;

    // NOTE: sync flops preset to 1 (idle bus level) so leaving reset cannot fake a START or STOP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_ff <= '1;
            sda_ff <= '1;
            scl_d  <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_ff <= {scl_ff[SYNC_STAGES-2:0], scl_in};
            sda_ff <= {sda_ff[SYNC_STAGES-2:0], sda_in};
            scl_d  <= scl_s;
            sda_d  <= sda_s;
        end
    end

    assign scl_s     = scl_ff[SYNC_STAGES-1];
    assign sda_s     = sda_ff[SYNC_STAGES-1];
    assign scl_rise  =  scl_s & ~scl_d;
    assign scl_fall  = ~scl_s &  scl_d;
    // SCL must be high on both samples so an SDA edge racing an SCL edge is not a bus condition.
    assign start_det = scl_s & scl_d &  sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d &  sda_s;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target (responder): address match, ACK generation and byte transfer in both directions.
// Optional macro I2C_GENERAL_CALL_EN adds general-call (8'h00 write) support and a gcall output.
module i2c_slave_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       rw,
    output logic       busy,
    output logic       stop_det
`ifdef I2C_GENERAL_CALL_EN
    ,
    output logic       gcall
`endif
);

    localparam logic [2:0] LAST_BIT = 3'(I2C_BYTE_BITS - 1);

    logic       sda_s, scl_rise, scl_fall, bus_start, bus_stop;
    logic [2:0] state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       got_byte;
    logic       addr_ok;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (bus_start),
        .stop_det  (bus_stop)
    );

`ifdef I2C_GENERAL_CALL_EN
    logic gcall_match;
    assign gcall_match = (shreg == 8'h00);
    assign addr_ok     = addr_hit(shreg, SLAVE_ADDR) | gcall_match;

    always_ff @(posedge clk) begin
        if (!rst_n || bus_start || bus_stop)
            gcall <= 1'b0;
        else if (state == ADDR && scl_fall && got_byte)
            gcall <= gcall_match;
    end
`else
    assign addr_ok = addr_hit(shreg, SLAVE_ADDR);
`endif

    // NOTE: every register here uses <= so all branches see the pre-edge state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            got_byte <= 1'b0;
            sda_oe   <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            rw       <= 1'b0;
            busy     <= 1'b0;
            stop_det <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            stop_det <= 1'b0;
            if (bus_stop) begin
                state    <= IDLE;
                sda_oe   <= 1'b0;
                busy     <= 1'b0;
                stop_det <= 1'b1;
            end else if (bus_start) begin
                state    <= ADDR;
                bit_cnt  <= '0;
                got_byte <= 1'b0;
                sda_oe   <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda_s};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == LAST_BIT) begin
                                got_byte <= 1'b1;
                                rw       <= sda_s;
                            end
                        end else if (scl_fall && got_byte) begin
                            got_byte <= 1'b0;
                            if (addr_ok) begin
                                state  <= ADDR_ACK;
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                            end else begin
                                state  <= WAIT_STOP;
                                sda_oe <= 1'b0;
                                busy   <= 1'b0;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_rise && rw) begin
                            tx_req <= 1'b1;
                        end else if (scl_fall) begin
                            bit_cnt <= '0;
                            if (rw) begin
                                shreg  <= tx_data;
                                sda_oe <= ~tx_data[7];
                                state  <= RD_DATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= WR_DATA;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda_s};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == LAST_BIT) begin
                                rx_data  <= {shreg[6:0], sda_s};
                                rx_valid <= 1'b1;
                                got_byte <= 1'b1;
                            end
                        end else if (scl_fall && got_byte) begin
                            got_byte <= 1'b0;
                            sda_oe   <= 1'b1;
                            state    <= WR_ACK;
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= WR_DATA;
                        end
                    end
                    RD_DATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == LAST_BIT) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= RD_ACK;
                            end else begin
                                shreg   <= {shreg[6:0], 1'b0};
                                sda_oe  <= ~shreg[6];
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            if (sda_s == I2C_ACK) begin
                                tx_req <= 1'b1;
                            end else begin
                                state <= WAIT_STOP;
                                busy  <= 1'b0;
                            end
                        end else if (scl_fall) begin
                            shreg   <= tx_data;
                            sda_oe  <= ~tx_data[7];
                            bit_cnt <= '0;
                            state   <= RD_DATA;
                        end
                    end
                    default: sda_oe <= 1'b0;
                endcase
            end
        end
    end

endmodule
